ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/ram_responder_if.sv | 31 +++
 rtl/ram_responder.sv | 118 +++++++++++
 tb/tb_ram_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_responder_if.sv
// ram_responder_if -- requester/responder bundle for the latency-modelling RAM.
//
// Signals
//   ramREN   : read request, held by the requester until ACCESS
//   ramWEN   : write request, held by the requester until ACCESS
//   ramaddr  : byte address
//   ramstore : write data
//   ramload  : read data (non-zero only during a read ACCESS cycle)
//   ramstate : FREE=0, BUSY=1, ACCESS=2, ERROR=3
//
// Modports
//   master : the requester (CPU side)
//   slave  : the RAM responder
interface ram_responder_if;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;

   modport master (
      output ramREN, ramWEN, ramaddr, ramstore,
      input  ramload, ramstate
   );

   modport slave (
      input  ramREN, ramWEN, ramaddr, ramstore,
      output ramload, ramstate
   );
endinterface

// File: rtl/ram_responder.sv
// ram_responder -- word-addressed RAM model with a programmable access latency.
//
// A request (read or write) must be held; the responder reports LAT BUSY
// cycles followed by one ACCESS cycle. Reads return data combinationally in
// the ACCESS cycle, writes commit on the edge that ends the ACCESS cycle.
// Illegal requests (read+write together, address beyond the array) report
// ERROR and never touch storage.
//
// Parameters
//   LAT   : BUSY cycles before ACCESS (0..15)
//   DEPTH : storage size in 32-bit words (power of two, >= 2)
//
// Ports
//   CLK  : clock, all state changes on the rising edge
//   nRST : asynchronous active-low reset (clears counter, request copy, storage)
//   bus  : ram_responder_if.slave request/response bundle
//
// Optional feature
//   RAM_ALIGN_CHECK_EN : when defined, addresses with ramaddr[1:0] != 0 are
//                        illegal; otherwise the low two bits are ignored.
module ram_responder #(
   parameter int unsigned LAT   = 2,
   parameter int unsigned DEPTH = 256
) (
   input  logic           CLK,
   input  logic           nRST,
   ram_responder_if.slave bus
);

   localparam int unsigned AW         = $clog2(DEPTH);
   localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   logic [3:0]    cnt;
   logic [1:0]    op_reg;      // {REN, WEN} seen in the previous cycle
   logic [31:0]   addr_reg;    // ramaddr seen in the previous cycle
   logic [31:0]   mem [DEPTH];

   logic [1:0]    op;
   logic          addr_oob;
   logic          misalign;
   logic          illegal;
   logic          same_req;
   logic [3:0]    cnt_eff;
   logic [AW-1:0] idx;
   logic          write_en;
   ramstate_t     state;

   assign op  = {bus.ramREN, bus.ramWEN};
   assign idx = bus.ramaddr[AW+1:2];

   always_comb begin
      addr_oob = {1'b0, bus.ramaddr} >= ADDR_LIMIT;
`ifdef RAM_ALIGN_CHECK_EN
      misalign = |bus.ramaddr[1:0];
`else
      misalign = 1'b0;
`endif
      illegal  = (op == 2'b11) || addr_oob || misalign;
      same_req = (op == op_reg) && (bus.ramaddr == addr_reg);
      // The stored count only belongs to the request it was accumulated for;
      // any change of op or address is seen as a fresh request starting at 0,
      // so the very first cycle of a new request already counts as BUSY #1.
      cnt_eff  = same_req ? cnt : 4'd0;

      if (!nRST || op == 2'b00) begin
         state = FREE;
      end else if (illegal) begin
         state = ERROR;
      end else if (cnt_eff == 4'(LAT)) begin
         state = ACCESS;
      end else begin
         state = BUSY;
      end
   end

   assign write_en     = (state == ACCESS) && bus.ramWEN;
   assign bus.ramstate = state;
   assign bus.ramload  = (state == ACCESS && bus.ramREN) ? mem[idx] : 32'd0;

   // Latency counter and request copy.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt      <= 4'd0;
         op_reg   <= 2'b00;
         addr_reg <= 32'd0;
      end else begin
         op_reg   <= op;
         addr_reg <= bus.ramaddr;
         case (state)
            BUSY:    cnt <= cnt_eff + 4'd1;
            ERROR:   cnt <= cnt;
            // ACCESS restarts the wait so a held request is served again
            // after another LAT cycles; FREE simply clears.
            default: cnt <= 4'd0;
         endcase
      end
   end

   // Storage: cleared as a whole on reset, written only at the end of a
   // write ACCESS cycle.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= 32'd0;
         end
      end else if (write_en) begin
         mem[idx] <= bus.ramstore;
      end
   end

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder -- scoreboard bench for ram_responder.
//
// Two responders (LAT=2 and LAT=0) receive identical stimulus. For every
// driven cycle the expected ramstate/ramload of each DUT is pushed into a
// per-DUT queue; a monitor pops one entry per DUT on every falling edge and
// compares. Expectations come from a transaction-level model: a request held
// for n cycles shows BUSY for LAT cycles then ACCESS, repeating; storage is a
// plain array updated at each write ACCESS.
module tb_ram_responder;

   localparam int DEPTH = 256;
   localparam int NDUT  = 2;

   localparam logic [1:0] S_FREE   = 2'd0;
   localparam logic [1:0] S_BUSY   = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_ERROR  = 2'd3;

   typedef struct packed {
      logic [1:0]  st;
      logic [31:0] ld;
   } exp_t;

   logic CLK  = 1'b0;
   logic nRST = 1'b1;

   ram_responder_if if_a ();
   ram_responder_if if_b ();

   ram_responder #(.LAT(2), .DEPTH(DEPTH)) u_lat2 (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (if_a)
   );

   ram_responder #(.LAT(0), .DEPTH(DEPTH)) u_lat0 (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (if_b)
   );

   always #5 CLK = ~CLK;

   exp_t        q_a[$];
   exp_t        q_b[$];
   logic [31:0] mem_m [NDUT][DEPTH];
   int          total = 0;
   int          bad   = 0;
   int          txn   = 0;
   logic        prev_ren  = 1'b0;
   logic        prev_wen  = 1'b0;
   logic [31:0] prev_addr = 32'd0;

   function automatic int lat_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   function automatic logic model_illegal(input logic ren, input logic wen,
                                          input logic [31:0] addr);
      logic bad_req;
      bad_req = (ren && wen) || (addr >= 32'(DEPTH * 4));
`ifdef RAM_ALIGN_CHECK_EN
      if (addr[1:0] != 2'b00) bad_req = 1'b1;
`endif
      return bad_req;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   task automatic clear_model();
      for (int d = 0; d < NDUT; d++)
         for (int w = 0; w < DEPTH; w++)
            mem_m[d][w] = 32'd0;
   endtask

   // Expected response of DUT d in cycle i of a held request.
   task automatic push_expect(input int d, input logic ren, input logic wen,
                              input logic [31:0] addr, input logic [31:0] data,
                              input int i);
      exp_t e;
      int   lat;
      int   w;
      lat  = lat_of(d);
      e.st = S_FREE;
      e.ld = 32'd0;
      if (nRST && (ren || wen)) begin
         if (model_illegal(ren, wen, addr)) begin
            e.st = S_ERROR;
         end else if ((i % (lat + 1)) != lat) begin
            e.st = S_BUSY;
         end else begin
            e.st = S_ACCESS;
            w = int'(addr >> 2);
            if (ren) e.ld = mem_m[d][w];
            else     mem_m[d][w] = data;
         end
      end
      if (d == 0) q_a.push_back(e);
      else        q_b.push_back(e);
   endtask

   task automatic drive_cycle(input logic rst_val, input logic ren, input logic wen,
                              input logic [31:0] addr, input logic [31:0] data,
                              input int i);
      @(posedge CLK);
      #1;
      if (nRST && !rst_val) clear_model();
      nRST          = rst_val;
      if_a.ramREN   = ren;
      if_a.ramWEN   = wen;
      if_a.ramaddr  = addr;
      if_a.ramstore = data;
      if_b.ramREN   = ren;
      if_b.ramWEN   = wen;
      if_b.ramaddr  = addr;
      if_b.ramstore = data;
      push_expect(0, ren, wen, addr, data, i);
      push_expect(1, ren, wen, addr, data, i);
   endtask

   // One transaction: a request held for n cycles. A non-idle request equal
   // to the previous cycle's gets an idle cycle first so it starts fresh.
   task automatic do_req(input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [31:0] data, input int n);
      if ((ren || wen) && ren == prev_ren && wen == prev_wen && addr == prev_addr)
         drive_cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 0);
      for (int i = 0; i < n; i++)
         drive_cycle(1'b1, ren, wen, addr, data, i);
      prev_ren  = ren;
      prev_wen  = wen;
      prev_addr = addr;
      txn++;
      $display("txn %0d: ren=%b wen=%b addr=%h data=%h cycles=%0d",
               txn, ren, wen, addr, data, n);
   endtask

   // Reset held for n cycles while the given request stays on the bus.
   task automatic do_reset(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] data, input int n);
      for (int i = 0; i < n; i++)
         drive_cycle(1'b0, ren, wen, addr, data, i);
      drive_cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 0);
      prev_ren  = 1'b0;
      prev_wen  = 1'b0;
      prev_addr = 32'd0;
      txn++;
      $display("txn %0d: reset for %0d cycles", txn, n);
   endtask

   // Monitor / scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("lat2 ramstate", 32'(if_a.ramstate), 32'(e.st));
            check("lat2 ramload", if_a.ramload, e.ld);
         end
         if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("lat0 ramstate", 32'(if_b.ramstate), 32'(e.st));
            check("lat0 ramload", if_b.ramload, e.ld);
         end
      end
   end

   // Watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        ren, wen;
      logic [31:0] addr, data;
      int          sel, asel, n;

      if_a.ramREN = 1'b0; if_a.ramWEN = 1'b0; if_a.ramaddr = 32'd0; if_a.ramstore = 32'd0;
      if_b.ramREN = 1'b0; if_b.ramWEN = 1'b0; if_b.ramaddr = 32'd0; if_b.ramstore = 32'd0;
      clear_model();
      #1;
      nRST = 1'b0;

      // Power-up reset with a request on the bus: must read FREE / 0.
      do_reset(1'b1, 1'b0, 32'h10, 32'h0, 3);

      // Write then read back (BUSY, BUSY, ACCESS for LAT=2).
      do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3);
      do_req(1'b1, 1'b0, 32'h10, 32'h0, 3);

      // Address change after one BUSY cycle restarts the full wait.
      do_req(1'b0, 1'b1, 32'h24, 32'hA5A50009, 3);
      do_req(1'b1, 1'b0, 32'h20, 32'h0, 1);
      do_req(1'b1, 1'b0, 32'h24, 32'h0, 3);

      // Read+write together is ERROR and leaves storage alone.
      do_req(1'b0, 1'b0, 32'h0, 32'h0, 1);
      do_req(1'b1, 1'b1, 32'h30, 32'hBADBAD00, 3);
      do_req(1'b1, 1'b0, 32'h30, 32'h0, 3);

      // Out-of-range and unaligned addresses.
      do_req(1'b1, 1'b0, 32'h400, 32'h0, 2);
      do_req(1'b0, 1'b1, 32'h400, 32'h11111111, 3);
      do_req(1'b1, 1'b0, 32'h12, 32'h0, 3);
      do_req(1'b0, 1'b1, 32'h13, 32'h22222222, 3);
      do_req(1'b1, 1'b0, 32'h10, 32'h0, 3);

      // Back-to-back reads at 0x0 / 0x4 (ACCESS every cycle on LAT=0).
      do_req(1'b0, 1'b1, 32'h0, 32'h01010101, 3);
      do_req(1'b0, 1'b1, 32'h4, 32'h02020202, 3);
      do_req(1'b1, 1'b0, 32'h0, 32'h0, 1);
      do_req(1'b1, 1'b0, 32'h4, 32'h0, 1);
      do_req(1'b1, 1'b0, 32'h0, 32'h0, 1);

      // Reset during the BUSY phase of a write; the write must not survive.
      do_req(1'b0, 1'b1, 32'h8, 32'h12345678, 1);
      do_reset(1'b0, 1'b1, 32'h8, 32'h12345678, 2);
      do_req(1'b1, 1'b0, 32'h8, 32'h0, 3);
      do_req(1'b1, 1'b0, 32'h10, 32'h0, 3);

      // Randomized traffic over a small window of words so reads hit writes.
      for (int t = 0; t < 150; t++) begin
         sel  = int'($urandom_range(0, 9));
         asel = int'($urandom_range(0, 9));
         n    = int'($urandom_range(1, 6));
         data = $urandom;
         ren  = (sel >= 1 && sel <= 4) || sel == 8;
         wen  = (sel >= 5 && sel <= 8);
         if (sel == 9) begin
            ren = $urandom_range(0, 1) == 1;
            wen = !ren;
         end
         if (asel < 7)       addr = 32'($urandom_range(0, 15)) << 2;
         else if (asel == 7) addr = (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(1, 3));
         else if (asel == 8) addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 4095));
         else                addr = $urandom | 32'h8000_0000;
         if (!ren && !wen) addr = 32'd0;
         do_req(ren, wen, addr, data, n);
      end

      do_req(1'b0, 1'b0, 32'h0, 32'h0, 2);
      @(negedge CLK);
      #1;
      check("lat2 queue drained", 32'(q_a.size()), 32'd0);
      check("lat0 queue drained", 32'(q_b.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
